// File: rtl/uart_configurable_if.sv
// Ready/valid bundle between a uart_configurable and its on-chip users.
// master = producer/consumer logic, slave = the UART itself.
interface uart_configurable_if #(
    parameter int DataBits = 8
);
    logic [DataBits-1:0] DataIn;
    logic                DataInValid;
    logic                DataInReady;
    logic [DataBits-1:0] DataOut;
    logic                DataOutValid;
    logic                DataOutReady;
    logic                ParityError;
    logic                FramingError;
    logic                Overrun;

    modport master (
        output DataIn, DataInValid, DataOutReady,
        input  DataInReady, DataOut, DataOutValid,
        input  ParityError, FramingError, Overrun
    );

    modport slave (
        input  DataIn, DataInValid, DataOutReady,
        output DataInReady, DataOut, DataOutValid,
        output ParityError, FramingError, Overrun
    );
endinterface

// File: rtl/uart_configurable.sv
// Full-duplex UART with configurable width, parity and stop bits.
// TX and RX share the baud divisor; RX reports parity/framing/overrun.
module uart_configurable #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200,
    parameter int DataBits  = 8,
    parameter int Parity    = 0,
    parameter int StopBits  = 1
) (
    input  logic               Clock,
    input  logic               ResetN,
    uart_configurable_if.slave bus,
    input  logic               SIn,
    output logic               SOut
);
    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int HasParity = (Parity != 0) ? 1 : 0;
    localparam int FrameBits = 1 + DataBits + HasParity + StopBits;
    localparam int CntW = $clog2(SymbolEdgeTime);
    localparam logic [CntW-1:0] SymLast = CntW'(SymbolEdgeTime - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(SymbolEdgeTime / 2 - 1);
    localparam logic [3:0] TxLast = 4'(FrameBits - 1);
    localparam logic [3:0] DataLast = 4'(DataBits - 1);
    localparam logic [3:0] StopLast = 4'(StopBits - 1);
    localparam logic OddPar = (Parity == 1);

    typedef enum logic {TxIdle, TxShift} txState_t;
    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop
    } rxState_t;

    txState_t txState, txNext;
    logic [FrameBits-1:0] txShift, txFrame;
    logic [CntW-1:0] txCnt;
    logic [3:0] txBit;
    logic txArmed, txTick, txAccept, txDone;

    rxState_t rxState, rxNext;
    logic sinMeta, sinSync, sinPrev, rxFall;
    logic [CntW-1:0] rxCnt;
    logic [3:0] rxBit;
    logic [DataBits-1:0] rxShift;
    logic rxParErr, rxFrameErr, rxTick, rxDone, consume;

    assign txTick = (txCnt == SymLast);
    assign txAccept = bus.DataInValid & bus.DataInReady;
    assign txDone = (txState == TxShift) & txTick & (txBit == TxLast);
    assign bus.DataInReady = txArmed & (txState == TxIdle);
    assign SOut = txShift[0];

    // Assemble the whole frame, LSB first, idle-high padding on top.
    always_comb begin
        txFrame = '1;
        txFrame[0] = 1'b0;
        txFrame[DataBits:1] = bus.DataIn;
        if (HasParity != 0)
            txFrame[DataBits+1] = OddPar ? ~^bus.DataIn : ^bus.DataIn;
    end

    // TX state register.
    always_ff @(posedge Clock) begin
        if (!ResetN) txState <= TxIdle;
        else txState <= txNext;
    end

    // TX next state.
    always_comb begin
        txNext = txState;
        unique case (txState)
            TxIdle:  if (txAccept) txNext = TxShift;
            TxShift: if (txDone) txNext = TxIdle;
            default: txNext = TxIdle;
        endcase
    end

    // TX shifter; refills with ones so SOut idles high straight from a flop.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            txShift <= '1;
            txCnt   <= '0;
            txBit   <= '0;
            txArmed <= 1'b0;
        end else begin
            txArmed <= 1'b1;
            if (txAccept) begin
                txShift <= txFrame;
                txCnt   <= '0;
                txBit   <= '0;
            end else if (txState == TxShift) begin
                if (txTick) begin
                    txShift <= {1'b1, txShift[FrameBits-1:1]};
                    txCnt   <= '0;
                    txBit   <= txBit + 4'd1;
                end else begin
                    txCnt <= txCnt + 1'b1;
                end
            end
        end
    end

    assign rxFall = sinPrev & ~sinSync;
    assign consume = bus.DataOutValid & bus.DataOutReady;

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            sinMeta <= 1'b1;
            sinSync <= 1'b1;
            sinPrev <= 1'b1;
        end else begin
            sinMeta <= SIn;
            sinSync <= sinMeta;
            sinPrev <= sinSync;
        end
    end

    // RX state register.
    always_ff @(posedge Clock) begin
        if (!ResetN) rxState <= RxIdle;
        else rxState <= rxNext;
    end

    // RX next state; rxTick marks each mid-symbol sample point.
    always_comb begin
        rxNext = rxState;
        rxTick = 1'b0;
        rxDone = 1'b0;
        unique case (rxState)
            RxIdle: if (rxFall) rxNext = RxStart;
            RxStart: if (rxCnt == HalfLast) begin
                rxTick = 1'b1;
                rxNext = sinSync ? RxIdle : RxData;
            end
            RxData: if (rxCnt == SymLast) begin
                rxTick = 1'b1;
                if (rxBit == DataLast)
                    rxNext = (HasParity != 0) ? RxParity : RxStop;
            end
            RxParity: if (rxCnt == SymLast) begin
                rxTick = 1'b1;
                rxNext = RxStop;
            end
            RxStop: if (rxCnt == SymLast) begin
                rxTick = 1'b1;
                if (rxBit == StopLast) begin
                    rxDone = 1'b1;
                    rxNext = RxIdle;
                end
            end
            default: rxNext = RxIdle;
        endcase
    end

    // RX counters, data shifter and per-frame error accumulation.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            rxCnt      <= '0;
            rxBit      <= '0;
            rxShift    <= '0;
            rxParErr   <= 1'b0;
            rxFrameErr <= 1'b0;
        end else begin
            if (rxState == RxIdle || rxTick) rxCnt <= '0;
            else rxCnt <= rxCnt + 1'b1;
            if (rxNext != rxState) rxBit <= '0;
            else if (rxTick) rxBit <= rxBit + 4'd1;
            if (rxState == RxStart) begin
                rxParErr   <= 1'b0;
                rxFrameErr <= 1'b0;
            end
            if (rxTick && rxState == RxData)
                rxShift <= {sinSync, rxShift[DataBits-1:1]};
            if (rxTick && rxState == RxParity)
                rxParErr <= ((^rxShift) ^ sinSync) != OddPar;
            if (rxTick && rxState == RxStop && !sinSync)
                rxFrameErr <= 1'b1;
        end
    end

    // Output holding register: load on completion, flag overrun if full.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            bus.DataOut      <= '0;
            bus.DataOutValid <= 1'b0;
            bus.ParityError  <= 1'b0;
            bus.FramingError <= 1'b0;
            bus.Overrun      <= 1'b0;
        end else if (rxDone && (!bus.DataOutValid || consume)) begin
            bus.DataOut      <= rxShift;
            bus.DataOutValid <= 1'b1;
            bus.ParityError  <= rxParErr;
            bus.FramingError <= rxFrameErr | ~sinSync;
            bus.Overrun      <= 1'b0;
        end else if (rxDone) begin
            bus.Overrun <= 1'b1;
        end else if (consume) begin
            bus.DataOutValid <= 1'b0;
            bus.ParityError  <= 1'b0;
            bus.FramingError <= 1'b0;
            bus.Overrun      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_configurable.sv
// Directed bench for uart_configurable: loopback, 7E2 TX, 8O1 RX,
// framing, overrun, glitch rejection and mid-frame reset.
module tb_uart_configurable;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_configurable_if #(.DataBits(8)) ifA ();
    uart_configurable_if #(.DataBits(8)) ifB ();
    uart_configurable_if #(.DataBits(7)) ifC ();
    uart_configurable_if #(.DataBits(8)) ifD ();
    uart_configurable_if #(.DataBits(8)) ifE ();

    logic lineAB, lineBA, lineC, sD, sE, outD, outE;

    uart_configurable #(.ClockFreq(1_000_000), .BaudRate(100_000),
        .DataBits(8), .Parity(0), .StopBits(1)) uA (
        .Clock(clk), .ResetN(rstN), .bus(ifA), .SIn(lineBA), .SOut(lineAB));
    uart_configurable #(.ClockFreq(1_000_000), .BaudRate(100_000),
        .DataBits(8), .Parity(0), .StopBits(1)) uB (
        .Clock(clk), .ResetN(rstN), .bus(ifB), .SIn(lineAB), .SOut(lineBA));
    uart_configurable #(.ClockFreq(1_000_000), .BaudRate(100_000),
        .DataBits(7), .Parity(2), .StopBits(2)) uC (
        .Clock(clk), .ResetN(rstN), .bus(ifC), .SIn(1'b1), .SOut(lineC));
    uart_configurable #(.ClockFreq(1_000_000), .BaudRate(100_000),
        .DataBits(8), .Parity(1), .StopBits(1)) uD (
        .Clock(clk), .ResetN(rstN), .bus(ifD), .SIn(sD), .SOut(outD));
    uart_configurable #(.ClockFreq(1_000_000), .BaudRate(100_000),
        .DataBits(8), .Parity(0), .StopBits(1)) uE (
        .Clock(clk), .ResetN(rstN), .bus(ifE), .SIn(sE), .SOut(outE));

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // {valid, overrun, parity error, framing error, data}
    function automatic logic [11:0] rxView(input int which);
        case (which)
            1: return {ifB.DataOutValid, ifB.Overrun, ifB.ParityError,
                       ifB.FramingError, ifB.DataOut};
            2: return {ifD.DataOutValid, ifD.Overrun, ifD.ParityError,
                       ifD.FramingError, ifD.DataOut};
            default: return {ifE.DataOutValid, ifE.Overrun, ifE.ParityError,
                             ifE.FramingError, ifE.DataOut};
        endcase
    endfunction

    task automatic setReady(input int which, input logic v);
        case (which)
            1: ifB.DataOutReady = v;
            2: ifD.DataOutReady = v;
            default: ifE.DataOutReady = v;
        endcase
    endtask

    task automatic setLine(input int which, input logic v);
        if (which == 2) sD = v;
        else sE = v;
    endtask

    task automatic driveBit(input int which, input logic b);
        setLine(which, b);
        repeat (10) @(negedge clk);
    endtask

    task automatic sendFrame(input int which, input logic [7:0] d,
                             input bit hasPar, input logic pbit,
                             input logic stopVal);
        driveBit(which, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(which, d[i]);
        if (hasPar) driveBit(which, pbit);
        driveBit(which, stopVal);
        setLine(which, 1'b1);
    endtask

    task automatic waitRx(input int which, input string tag);
        int n;
        logic [11:0] v;
        exp_t e;
        n = 0;
        v = rxView(which);
        while (!v[11] && n < 400) begin
            @(negedge clk);
            n++;
            v = rxView(which);
        end
        check({tag, " valid"}, {31'd0, v[11]}, 32'd1);
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL %s sbq: observed empty expected an entry", tag);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({tag, " data"}, {24'd0, v[7:0]}, {24'd0, e.data});
            check({tag, " perr"}, {31'd0, v[9]}, {31'd0, e.pe});
            check({tag, " ferr"}, {31'd0, v[8]}, {31'd0, e.fe});
        end
    endtask

    task automatic consume(input int which, input string tag);
        logic [11:0] v;
        @(negedge clk);
        setReady(which, 1'b1);
        @(posedge clk);
        #1;
        setReady(which, 1'b0);
        v = rxView(which);
        check({tag, " consumed"}, {31'd0, v[11]}, 32'd0);
        check({tag, " ovr clr"}, {31'd0, v[10]}, 32'd0);
    endtask

    task automatic loopByte(input logic [7:0] b);
        int n;
        @(negedge clk);
        n = 0;
        while (!ifA.DataInReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        ifA.DataIn = b;
        ifA.DataInValid = 1'b1;
        sbq.push_back('{data: b, pe: 1'b0, fe: 1'b0});
        @(posedge clk);
        #1;
        ifA.DataInValid = 1'b0;
        waitRx(1, "loop");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("loop hold", {24'd0, ifB.DataOut}, {24'd0, b});
            check("loop idle", {31'd0, lineAB}, 32'd1);
        end
        consume(1, "loop");
    endtask

    initial begin
        logic [6:0] d7;
        logic [10:0] ef;
        logic [7:0] d8;
        logic pbit;
        bit seen;

        ifA.DataIn = '0; ifA.DataInValid = 0; ifA.DataOutReady = 0;
        ifB.DataIn = '0; ifB.DataInValid = 0; ifB.DataOutReady = 0;
        ifC.DataIn = '0; ifC.DataInValid = 0; ifC.DataOutReady = 0;
        ifD.DataIn = '0; ifD.DataInValid = 0; ifD.DataOutReady = 0;
        ifE.DataIn = '0; ifE.DataInValid = 0; ifE.DataOutReady = 0;
        sD = 1'b1;
        sE = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst SOut", {31'd0, lineAB}, 32'd1);
        check("rst ready", {31'd0, ifA.DataInReady}, 32'd0);
        check("rst valid", {31'd0, ifB.DataOutValid}, 32'd0);
        check("rst data", {24'd0, ifB.DataOut}, 32'd0);
        check("rst perr", {31'd0, ifB.ParityError}, 32'd0);
        check("rst ferr", {31'd0, ifB.FramingError}, 32'd0);
        check("rst ovr", {31'd0, ifB.Overrun}, 32'd0);

        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        check("rel ready", {31'd0, ifA.DataInReady}, 32'd1);

        loopByte(8'h21);
        loopByte(8'hBF);

        d7 = 7'h55;
        ef = {2'b11, ^d7, d7, 1'b0};
        @(negedge clk);
        ifC.DataIn = d7;
        ifC.DataInValid = 1'b1;
        @(posedge clk);
        #1;
        ifC.DataInValid = 1'b0;
        ifC.DataIn = 7'h2A;
        for (int i = 0; i < 11; i++) begin
            repeat (5) @(posedge clk);
            #1;
            check($sformatf("7e2 bit%0d", i), {31'd0, lineC},
                  {31'd0, ef[i]});
            if (i == 10)
                check("7e2 busy", {31'd0, ifC.DataInReady}, 32'd0);
            repeat (5) @(posedge clk);
        end
        #1;
        check("7e2 ready", {31'd0, ifC.DataInReady}, 32'd1);

        d8 = 8'hA5;
        pbit = 1'b0;
        sbq.push_back('{data: d8, pe: (((^d8) ^ pbit) == 1'b0), fe: 1'b0});
        @(negedge clk);
        sendFrame(2, d8, 1'b1, pbit, 1'b1);
        waitRx(2, "8o1");
        consume(2, "8o1");

        sbq.push_back('{data: 8'h3C, pe: 1'b0, fe: 1'b1});
        @(negedge clk);
        sendFrame(3, 8'h3C, 1'b0, 1'b0, 1'b0);
        waitRx(3, "frame");
        consume(3, "frame");
        repeat (30) @(negedge clk);

        sbq.push_back('{data: 8'h11, pe: 1'b0, fe: 1'b0});
        sendFrame(3, 8'h11, 1'b0, 1'b0, 1'b1);
        sendFrame(3, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        waitRx(3, "ovr");
        check("ovr flag", {31'd0, ifE.Overrun}, 32'd1);
        consume(3, "ovr");

        repeat (30) @(negedge clk);
        sE = 1'b0;
        repeat (3) @(negedge clk);
        sE = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (ifE.DataOutValid) seen = 1;
        end
        check("glitch", {31'd0, seen}, 32'd0);

        @(negedge clk);
        ifA.DataIn = 8'h00;
        ifA.DataInValid = 1'b1;
        @(posedge clk);
        #1;
        ifA.DataInValid = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        check("mid SOut", {31'd0, lineAB}, 32'd0);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        check("mid rst SOut", {31'd0, lineAB}, 32'd1);
        check("mid rst ready", {31'd0, ifA.DataInReady}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        check("mid rel ready", {31'd0, ifA.DataInReady}, 32'd1);
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (ifB.DataOutValid) seen = 1;
        end
        check("mid rx drop", {31'd0, seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
